// File: rtl/mem_bus.sv
// mem_bus: data RAM plus memory-mapped buffered UART transmitter and cycle counter
// behind the CPU memory port; reads are combinational, writes land on the clock edge.
module mem_bus #(
  parameter int RAM_WORDS  = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [7:0]  mem_addr,
  input  logic [15:0] mem_in,
  output logic [15:0] mem_out,
  output logic        tx,
  output logic        tx_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(BAUD_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [15:0]   ram [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cyc;
  logic [15:0]   cyc_hi, status;
  logic          ram_hit, push_req, push, pop, full, empty, ovf, ovf_set, ovf_clr;
  state_t        state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [2:0]    idx, idx_nx;
  logic [7:0]    sh, sh_nx;
  logic          tx_nx, bit_done;
  assign ram_hit  = int'(mem_addr) < RAM_WORDS;
  assign push_req = mem_we && mem_addr == 8'hF0;
  assign full     = count == CW'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign push     = push_req && !full;
  assign ovf_set  = push_req && full;
  assign ovf_clr  = mem_we && mem_addr == 8'hF1 && mem_in[3];
  assign bit_done = tmr == TW'(BAUD_DIV - 1);
  assign tx_busy  = state != IDLE || !empty;
  assign status   = {8'h00, 4'(count), ovf, state != IDLE, empty, full};
  always_ff @(posedge clk)
    if (mem_we && ram_hit) ram[mem_addr] <= mem_in;
  always_ff @(posedge clk)
    if (rst_n && push) fifo[wr_ptr] <= mem_in[7:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      cyc    <= '0;
      cyc_hi <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      ovf   <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf;
      cyc   <= (mem_we && mem_addr == 8'hF2) ? '0 : cyc + 1'b1;
      // Latching the high half on a LO read keeps an LO-then-HI read pair coherent
      if (!mem_we && mem_addr == 8'hF2) cyc_hi <= cyc[31:16];
    end
  end
  always_comb begin
    state_nx = state;
    tmr_nx   = (state == IDLE || bit_done) ? '0 : tmr + 1'b1;
    idx_nx   = idx;
    sh_nx    = sh;
    tx_nx    = tx;
    pop      = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          pop      = 1'b1;
          sh_nx    = fifo[rd_ptr];
          state_nx = START;
          tx_nx    = 1'b0;
        end
      START:
        if (bit_done) begin
          state_nx = DATA;
          idx_nx   = 3'd0;
          tx_nx    = sh[0];
        end
      DATA:
        if (bit_done) begin
          if (idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
            sh_nx  = sh >> 1;
            tx_nx  = sh[1];
          end
        end
      STOP:
        if (bit_done) begin
          // A queued byte starts its start bit immediately, with no idle gap
          if (!empty) begin
            pop      = 1'b1;
            sh_nx    = fifo[rd_ptr];
            state_nx = START;
            tx_nx    = 1'b0;
          end else state_nx = IDLE;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
      idx   <= idx_nx;
      sh    <= sh_nx;
      tx    <= tx_nx;
    end
  end
  always_comb
    mem_out = ram_hit ? ram[mem_addr] :
              mem_addr == 8'hF1 ? status :
              mem_addr == 8'hF2 ? cyc[15:0] :
              mem_addr == 8'hF3 ? cyc_hi : '0;
endmodule

// File: tb/tb_mem_bus.sv
// tb_mem_bus: directed steps for mem_bus; transmitted bytes are scoreboarded against
// a queue filled at push time and decoded from the tx line by a serial monitor.
module tb_mem_bus;
  localparam int BD = 4;
  localparam int FD = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [7:0]  mem_addr = 8'h00;
  logic [15:0] mem_in = 16'h0000;
  logic [15:0] mem_out;
  logic        tx, tx_busy;
  int          checks = 0;
  int          errors = 0;
  int          frames = 0;
  int          rst_edges = 0;
  logic [7:0]  sb [$];
  always #5 clk = ~clk;
  mem_bus #(.RAM_WORDS(240), .FIFO_DEPTH(FD), .BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_in(mem_in), .mem_out(mem_out), .tx(tx), .tx_busy(tx_busy)
  );
  always @(posedge clk) if (!rst_n) rst_edges <= rst_edges + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string tag);
    mem_we = 1'b0;
    mem_addr = a;
    #1;
    chk(tag, mem_out, exp);
  endtask
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    mem_addr = a;
    mem_in = d;
    mem_we = 1'b1;
    @(negedge clk);
    mem_we = 1'b0;
    mem_addr = 8'h00;
  endtask
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) f[i] = i < 4 ? 1'b0 : i >= 36 ? 1'b1 : b[(i - 4) / 4];
    return f;
  endfunction
  // Serial decoder: samples each bit mid-cell and pops the scoreboard per completed frame
  initial begin : monitor
    logic [7:0] b;
    logic s0, s1;
    int r0;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        r0 = rst_edges;
        repeat (BD / 2) @(negedge clk);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = tx;
        end
        repeat (BD) @(negedge clk);
        s1 = tx;
        if (rst_edges == r0) begin
          frames++;
          chk("frame_start_bit", s0, 0);
          chk("frame_stop_bit", s1, 1);
          chk("sb_frame_expected", sb.size() != 0, 1);
          if (sb.size() != 0) chk("sb_byte", b, sb.pop_front());
        end
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [39:0] got;
    logic [79:0] seq;
    logic still_high;
    int f0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    rd(8'hF1, 16'h0002, "rst_status");
    rd(8'hF3, 16'h0000, "rst_cyc_hi");
    rd(8'hF2, 16'h0000, "rst_cyc_lo");
    @(negedge clk);
    wr(8'h10, 16'hBEEF);
    wr(8'hEF, 16'h1234);
    rd(8'h10, 16'hBEEF, "ram_10");
    rd(8'hEF, 16'h1234, "ram_ef");
    rd(8'hF5, 16'h0000, "unmapped_f5");
    wr(8'hF5, 16'hFFFF);
    rd(8'hF5, 16'h0000, "unmapped_f5_after_wr");
    rd(8'h10, 16'hBEEF, "ram_10_after_f5_wr");
    rd(8'hF0, 16'h0000, "uart_data_reads_0");
    rd(8'hFF, 16'h0000, "addr_ff_reads_0");
    @(negedge clk);
    wr(8'hF0, 16'h00A5);
    sb.push_back(8'hA5);
    rd(8'hF1, 16'h0010, "push_count1_idle");
    chk("tx_high_before_pop", tx, 1);
    @(negedge clk);
    rd(8'hF1, 16'h0006, "popped_in_start");
    for (int i = 0; i < 40; i++) begin
      got[i] = tx;
      if (i == 39) chk("busy_last_stop_cycle", tx_busy, 1);
      @(negedge clk);
    end
    chk("single_frame_a5", got, frame_bits(8'hA5));
    chk("busy_after_frame", tx_busy, 0);
    chk("sb_empty_after_a5", sb.size(), 0);
    wr(8'hF0, 16'h0001);
    sb.push_back(8'h01);
    wr(8'hF0, 16'h0002);
    sb.push_back(8'h02);
    for (int i = 0; i < 80; i++) begin
      seq[i] = tx;
      if (i == 79) chk("b2b_busy_end", tx_busy, 1);
      @(negedge clk);
    end
    chk("b2b_frame1", seq[39:0], frame_bits(8'h01));
    chk("b2b_frame2_no_gap", seq[79:40], frame_bits(8'h02));
    chk("b2b_busy_after_80", tx_busy, 0);
    f0 = frames;
    for (int i = 0; i < 10; i++) begin
      wr(8'hF0, 16'(8'h30 + i));
      if (i < 9) sb.push_back(8'(8'h30 + i));
    end
    rd(8'hF1, 16'h008D, "ovf_full_status");
    wr(8'hF1, 16'h0008);
    rd(8'hF1, 16'h0085, "ovf_cleared_status");
    for (int i = 0; i < 600 && (sb.size() != 0 || tx_busy); i++) @(negedge clk);
    chk("ovf_drain_in_time", sb.size() == 0 && !tx_busy, 1);
    chk("ovf_nine_frames", frames - f0, 9);
    wr(8'hF2, 16'h0000);
    repeat (32'h10004) @(negedge clk);
    rd(8'hF2, 16'h0004, "cyc_lo");
    @(negedge clk);
    rd(8'hF3, 16'h0001, "cyc_hi_coherent");
    mem_addr = 8'h00;
    @(negedge clk);
    force dut.cyc = 32'hFFFF_FFFF;
    #1;
    release dut.cyc;
    rd(8'hF2, 16'hFFFF, "wrap_lo_before");
    @(negedge clk);
    rd(8'hF3, 16'hFFFF, "wrap_hi_shadow_before");
    rd(8'hF2, 16'h0000, "wrap_lo_after");
    @(negedge clk);
    rd(8'hF3, 16'h0000, "wrap_hi_after");
    mem_addr = 8'h00;
    @(negedge clk);
    wr(8'hF0, 16'h003C);
    wr(8'hF0, 16'h0077);
    repeat (10) @(negedge clk);
    chk("midframe_busy", tx_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    rd(8'hF1, 16'h0002, "midrst_status");
    chk("midrst_busy", tx_busy, 0);
    rst_n = 1'b1;
    still_high = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) still_high = 1'b0;
    end
    chk("no_residual_tx", still_high, 1);
    rd(8'hF1, 16'h0002, "post_rst_status");
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
